// File: rtl/uart_mem_loader.sv
// UART frame loader: A5, 16-bit word count, little-endian words, optional XOR byte.
// Define LOADER_CHECKSUM_EN to require and check the trailing checksum byte.
module uart_mem_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        MemWrite,
    output logic [31:0] DataAdr,
    output logic [31:0] WriteData,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    rx_state_t     rx_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          byte_valid;
    logic          byte_err;

    state_t        state;
    logic [15:0]   len;
    logic [15:0]   word_cnt;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [7:0]    chk;

    // shift holds the received byte until the next frame starts shifting
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL) begin
                        cnt        <= '0;
                        byte_valid <= 1'b1;
                        byte_err   <= !rx_sync;
                        rx_state   <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len       <= '0;
            word_cnt  <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            chk       <= '0;
            MemWrite  <= 1'b0;
            DataAdr   <= BASE_ADDR;
            WriteData <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            MemWrite <= 1'b0;
            if (byte_valid && byte_err &&
                state != S_DONE && state != S_ERROR) begin
                state <= S_ERROR;
                error <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (byte_valid && shift == 8'hA5) state <= S_LEN0;
                    end
                    S_LEN0: begin
                        if (byte_valid) begin
                            len[7:0] <= shift;
                            state    <= S_LEN1;
                        end
                    end
                    S_LEN1: begin
                        if (byte_valid) begin
                            len[15:8] <= shift;
                            word_cnt  <= '0;
                            byte_idx  <= '0;
                            chk       <= '0;
                            if ({shift, len[7:0]} != 16'd0) begin
                                state <= S_DATA;
                            end else begin
`ifdef LOADER_CHECKSUM_EN
                                state <= S_CHK;
`else
                                state     <= S_DONE;
                                done      <= 1'b1;
                                cpu_reset <= 1'b0;
`endif
                            end
                        end
                    end
                    S_DATA: begin
                        // the last strobe is allowed out before leaving DATA
                        if (MemWrite && word_cnt == len) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
`endif
                        end else if (byte_valid) begin
                            chk      <= chk ^ shift;
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx == 2'd3) begin
                                WriteData <= {shift, word_buf};
                                DataAdr   <= BASE_ADDR +
                                             {14'd0, word_cnt, 2'b00};
                                MemWrite  <= 1'b1;
                                word_cnt  <= word_cnt + 1'b1;
                            end else begin
                                word_buf <= {shift, word_buf[23:8]};
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (byte_valid) begin
                            if (shift == chk) begin
                                state     <= S_DONE;
                                done      <= 1'b1;
                                cpu_reset <= 1'b0;
                            end else begin
                                state <= S_ERROR;
                                error <= 1'b1;
                            end
                        end
                    end
`endif
                    S_DONE:  ;
                    S_ERROR: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader; frames built from word lists.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_uart_mem_loader;

    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [63:0] wr_q[$];
    logic [31:0] words[$];
    logic [7:0]  run_chk;
    logic        corrupt;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    // each strobe cycle is logged once with its address and data
    always @(posedge clk) begin
        if (MemWrite) wr_q.push_back({DataAdr, WriteData});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_hdr(input int n);
        logic [15:0] n16;
        n16 = 16'(n);
        run_chk = 8'h00;
        send_byte(8'hA5);
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            run_chk = run_chk ^ b;
            send_byte(b);
        end
    endtask

    task automatic send_frame();
        send_hdr(words.size());
        foreach (words[i]) send_word(words[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(run_chk ^ {7'd0, corrupt});
`endif
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_count"}, 32'(wr_q.size()), 32'(n));
        for (int k = 0; k < n && k < wr_q.size(); k++) begin
            check({tag, "_addr"}, wr_q[k][63:32], BASE + 32'(4 * k));
            check({tag, "_data"}, wr_q[k][31:0], words[k]);
        end
    endtask

    task automatic check_status(input string tag, input logic exp_done,
                                input logic exp_err);
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
        check({tag, "_memwrite"}, {31'd0, MemWrite}, 32'd0);
    endtask

    initial begin
        int          n;
        logic [7:0]  g;
        reset   = 1'b1;
        uart_rx = 1'b1;
        corrupt = 1'b0;

        do_reset();
        repeat (1000) @(negedge clk);
        check_status("idle", 1'b0, 1'b0);
        check("idle_adr", DataAdr, BASE);
        check("idle_wdata", WriteData, 32'd0);
        check("idle_writes", 32'(wr_q.size()), 32'd0);

        do_reset();
        wr_q.delete();
        words   = '{32'h00500113, 32'h00C00193};
        corrupt = 1'b0;
        send_frame();
        check_writes("two_words", 2);
        check_status("two_words", 1'b1, 1'b0);

        do_reset();
        wr_q.delete();
        send_byte(8'h12);
        send_byte(8'h34);
        check_status("garbage", 1'b0, 1'b0);
        words.delete();
        send_frame();
        check_writes("zero_len", 0);
        check_status("zero_len", 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        wr_q.delete();
        words   = '{32'h00500113, 32'h00C00193};
        corrupt = 1'b1;
        send_frame();
        check_writes("bad_chk", 2);
        check_status("bad_chk", 1'b0, 1'b1);
        corrupt = 1'b0;
`endif

        do_reset();
        wr_q.delete();
        words = '{$urandom, $urandom};
        send_hdr(2);
        send_word(words[0]);
        send_byte(8'h3C, 1'b0);
        repeat (CPB) @(negedge clk);
        check_status("framing", 1'b0, 1'b1);
        send_frame();
        check_writes("framing", 1);
        check_status("framing_after", 1'b0, 1'b1);

        do_reset();
        wr_q.delete();
        words = '{$urandom, $urandom, $urandom, $urandom};
        send_hdr(4);
        send_word(words[0]);
        send_word(words[1]);
        repeat (4) @(negedge clk);
        check_writes("partial", 2);
        do_reset();
        check_status("mid_reset", 1'b0, 1'b0);
        check("mid_reset_adr", DataAdr, BASE);
        check("mid_reset_wdata", WriteData, 32'd0);
        wr_q.delete();
        words   = '{$urandom, $urandom, $urandom};
        corrupt = 1'b0;
        send_frame();
        check_writes("reload", 3);
        check_status("reload", 1'b1, 1'b0);

        for (int it = 0; it < 4; it++) begin
            do_reset();
            wr_q.delete();
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g);
            end
            n = int'($urandom_range(1, 5));
            words.delete();
            for (int j = 0; j < n; j++) words.push_back($urandom);
`ifdef LOADER_CHECKSUM_EN
            corrupt = 1'($urandom_range(0, 1));
`else
            corrupt = 1'b0;
`endif
            send_frame();
            check_writes("random", n);
            check_status("random", !corrupt, corrupt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
